// File: rtl/fifo_arb_pkg.sv
// Shared types and the rotating-priority search used by the FIFO write arbiter
// and any other scheduler that needs a round-robin pick.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Upper bound on requesters the search function handles.
  localparam int RR_MAX_REQ = 32;
  localparam int RR_IDX_W   = 5;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req_valid, searching rr_ptr+1, rr_ptr+2, ... modulo num_req.
  function automatic rr_pick_t rr_next(input int                    num_req,
                                       input logic [RR_IDX_W-1:0]   rr_ptr,
                                       input logic [RR_MAX_REQ-1:0] req_valid);
    rr_pick_t            res;
    int                  cand;
    logic [RR_IDX_W-1:0] cand_idx;
    res = '0;
    for (int i = 1; i <= RR_MAX_REQ; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= num_req) cand = cand - num_req;
      cand_idx = cand[RR_IDX_W-1:0];
      if (!res.found && (i <= num_req)) begin
        if (req_valid[cand_idx]) begin
          res.found = 1'b1;
          res.idx   = cand_idx;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority picker: grants the first requester after rr_ptr.
// Supports up to RR_MAX_REQ requesters.
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [IDX_WIDTH-1:0] rr_ptr,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic                 found,
  output logic [IDX_WIDTH-1:0] idx
);

  rr_pick_t              pick;
  logic [RR_IDX_W-1:0]   ptr_ext;
  logic [RR_MAX_REQ-1:0] req_ext;

  always_comb begin
    ptr_ext = RR_IDX_W'(rr_ptr);
    req_ext = RR_MAX_REQ'(req_valid);
    pick    = rr_next(NUM_REQ, ptr_ext, req_ext);
    found   = pick.found;
    idx     = pick.idx[IDX_WIDTH-1:0];
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Packet-locked round-robin arbiter sharing one FIFO write port among NUM_REQ
// producers, writing only when a shadow occupancy count guarantees a free slot.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 32,
  parameter int IDX_WIDTH  = $clog2(NUM_REQ),
  parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_rd_en,
  input  logic                          fifo_busy,
  input  logic                          fifo_wr_err,
  input  logic                          fifo_rd_err,
  output logic                          grant_valid,
  output logic [IDX_WIDTH-1:0]          grant_idx,
  output logic [CNT_WIDTH-1:0]          occupancy,
  output logic                          err_sticky,
  input  logic                          err_clr,
  output arb_state_e                    state_dbg
);

  // Handshake: a beat moves in any cycle where req_valid[i] & req_ready[i] are
  // both high; ready never waits on valid, and producers hold valid/data/last
  // stable until accepted. fifo_wr_en is exactly that transfer condition.

  arb_state_e           state, state_nxt;
  logic                 grant_valid_nxt;
  logic [IDX_WIDTH-1:0] grant_idx_nxt;
  logic [IDX_WIDTH-1:0] rr_ptr, rr_ptr_nxt;
  logic [CNT_WIDTH-1:0] occ_nxt;
  logic                 err_nxt;
  logic                 space;
  logic                 pick_found;
  logic [IDX_WIDTH-1:0] pick_idx;
  logic                 rd_ok;
  logic                 underflow;

  rr_priority_picker #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_picker (
    .rr_ptr    (rr_ptr),
    .req_valid (req_valid),
    .found     (pick_found),
    .idx       (pick_idx)
  );

  // Space depends on registered state only, so ready never loops back through valid.
  assign space = (occupancy < CNT_WIDTH'(FIFO_DEPTH)) && !fifo_busy;

  always_comb begin
    req_ready = '0;
    if ((state == LOCKED) && space) req_ready[grant_idx] = 1'b1;
  end

  assign fifo_wr_en   = req_ready[grant_idx] & req_valid[grant_idx];
  assign fifo_wr_data = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign state_dbg    = state;

  always_comb begin
    state_nxt       = state;
    grant_valid_nxt = grant_valid;
    grant_idx_nxt   = grant_idx;
    rr_ptr_nxt      = rr_ptr;
    case (state)
      IDLE: begin
        // A restarting FIFO freezes arbitration as well as the lock.
        if (!fifo_busy && pick_found) begin
          state_nxt       = LOCKED;
          grant_valid_nxt = 1'b1;
          grant_idx_nxt   = pick_idx;
        end
      end
      LOCKED: begin
        if (fifo_wr_en && req_last[grant_idx]) begin
          state_nxt       = IDLE;
          grant_valid_nxt = 1'b0;
          rr_ptr_nxt      = grant_idx;
        end
      end
      default: begin
        state_nxt       = IDLE;
        grant_valid_nxt = 1'b0;
      end
    endcase
  end

  assign rd_ok     = fifo_rd_en && (occupancy != '0);
  assign underflow = fifo_rd_en && (occupancy == '0);

  always_comb begin
    occ_nxt = occupancy;
    if (fifo_busy)                occ_nxt = '0;
    else if (fifo_wr_en && !rd_ok) occ_nxt = occupancy + CNT_WIDTH'(1);
    else if (rd_ok && !fifo_wr_en) occ_nxt = occupancy - CNT_WIDTH'(1);
  end

  always_comb begin
    err_nxt = err_sticky;
    if (fifo_wr_err || fifo_rd_err || underflow) err_nxt = 1'b1;
    else if (err_clr)                           err_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      rr_ptr      <= IDX_WIDTH'(NUM_REQ - 1);
      occupancy   <= '0;
      err_sticky  <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant_valid <= grant_valid_nxt;
      grant_idx   <= grant_idx_nxt;
      rr_ptr      <= rr_ptr_nxt;
      occupancy   <= occ_nxt;
      err_sticky  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter with a 4-deep shadow FIFO and four requesters.
module tb_fifo_write_arbiter;
  import fifo_arb_pkg::*;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int FD = 4;
  localparam int IW = $clog2(NR);
  localparam int CW = $clog2(FD) + 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_last;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_wr_data;
  logic             fifo_rd_en;
  logic             fifo_busy;
  logic             fifo_wr_err;
  logic             fifo_rd_err;
  logic             grant_valid;
  logic [IW-1:0]    grant_idx;
  logic [CW-1:0]    occupancy;
  logic             err_sticky;
  logic             err_clr;
  arb_state_e       state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  fifo_write_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_busy    (fifo_busy),
    .fifo_wr_err  (fifo_wr_err),
    .fifo_rd_err  (fifo_rd_err),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .occupancy    (occupancy),
    .err_sticky   (err_sticky),
    .err_clr      (err_clr),
    .state_dbg    (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  // Driver helper
  task automatic set_data(input int idx, input logic [DW-1:0] val);
    req_data[idx*DW +: DW] = val;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    req_valid   = '0;
    req_last    = '0;
    req_data    = '0;
    fifo_rd_en  = 1'b0;
    fifo_busy   = 1'b0;
    fifo_wr_err = 1'b0;
    fifo_rd_err = 1'b0;
    err_clr     = 1'b0;

    // Reset state
    cyc();
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_gvalid", 32'(grant_valid), 32'd0);
    chk("rst_gidx", 32'(grant_idx), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_err", 32'(err_sticky), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    cyc();
    reset_n = 1'b1;

    // 3-beat packet from requester 0
    req_valid = 4'b0001;
    set_data(0, 16'hA000);
    #1;
    chk("p1_idle_state", 32'(state_dbg), 32'(IDLE));
    chk("p1_idle_wr", 32'(fifo_wr_en), 32'd0);
    cyc();
    chk("p1_gvalid", 32'(grant_valid), 32'd1);
    chk("p1_gidx", 32'(grant_idx), 32'd0);
    chk("p1_ready", 32'(req_ready), 32'b0001);
    chk("p1_wr0", 32'(fifo_wr_en), 32'd1);
    chk("p1_data0", 32'(fifo_wr_data), 32'hA000);
    cyc();
    set_data(0, 16'hA001);
    #1;
    chk("p1_wr1", 32'(fifo_wr_en), 32'd1);
    chk("p1_data1", 32'(fifo_wr_data), 32'hA001);
    chk("p1_occ1", 32'(occupancy), 32'd1);
    cyc();
    set_data(0, 16'hA002);
    req_last = 4'b0001;
    #1;
    chk("p1_wr2", 32'(fifo_wr_en), 32'd1);
    chk("p1_occ2", 32'(occupancy), 32'd2);
    cyc();
    req_valid = '0;
    req_last  = '0;
    #1;
    chk("p1_occ3", 32'(occupancy), 32'd3);
    chk("p1_gdrop", 32'(grant_valid), 32'd0);
    chk("p1_end_wr", 32'(fifo_wr_en), 32'd0);
    fifo_rd_en = 1'b1;
    repeat (3) cyc();
    fifo_rd_en = 1'b0;
    #1;
    chk("drain_occ", 32'(occupancy), 32'd0);
    chk("drain_err", 32'(err_sticky), 32'd0);

    // Round robin of 1-beat packets from all four requesters
    do_reset();
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    for (int i = 0; i < NR; i++) set_data(i, 16'hB000 + 16'(i));
    for (int k = 0; k < NR; k++) begin
      #1;
      chk("rr_idle_gap", 32'(grant_valid), 32'd0);
      chk("rr_idle_wr", 32'(fifo_wr_en), 32'd0);
      cyc();
      #1;
      chk("rr_gidx", 32'(grant_idx), 32'(k));
      chk("rr_wr", 32'(fifo_wr_en), 32'd1);
      chk("rr_data", 32'(fifo_wr_data), 32'hB000 + 32'(k));
      chk("rr_occ", 32'(occupancy), 32'(k));
      cyc();
    end
    #1;
    chk("rr_full_occ", 32'(occupancy), 32'd4);
    cyc();
    #1;
    chk("rr_wrap_gidx", 32'(grant_idx), 32'd0);
    chk("full_gvalid", 32'(grant_valid), 32'd1);
    chk("full_ready", 32'(req_ready), 32'd0);
    chk("full_wr", 32'(fifo_wr_en), 32'd0);
    // Read at the full boundary: still no write this cycle
    fifo_rd_en = 1'b1;
    #1;
    chk("full_rd_wr", 32'(fifo_wr_en), 32'd0);
    cyc();
    fifo_rd_en = 1'b0;
    #1;
    chk("full_rd_occ", 32'(occupancy), 32'd3);
    chk("full_next_wr", 32'(fifo_wr_en), 32'd1);
    chk("full_next_data", 32'(fifo_wr_data), 32'hB000);
    cyc();
    #1;
    chk("full_back_occ", 32'(occupancy), 32'd4);
    chk("full_back_gv", 32'(grant_valid), 32'd0);
    cyc();
    #1;
    chk("rr_after_wrap", 32'(grant_idx), 32'd1);

    // 6-beat packet into a 4-deep FIFO with no reads
    do_reset();
    req_valid = 4'b0001;
    req_last  = '0;
    set_data(0, 16'hC000);
    #1;
    chk("p6_idle", 32'(grant_valid), 32'd0);
    cyc();
    for (int b = 0; b < 4; b++) begin
      #1;
      chk("p6_wr", 32'(fifo_wr_en), 32'd1);
      chk("p6_data", 32'(fifo_wr_data), 32'hC000 + 32'(b));
      chk("p6_occ", 32'(occupancy), 32'(b));
      cyc();
      set_data(0, 16'hC000 + 16'(b + 1));
    end
    #1;
    chk("p6_stall_ready", 32'(req_ready), 32'd0);
    chk("p6_stall_wr", 32'(fifo_wr_en), 32'd0);
    chk("p6_stall_occ", 32'(occupancy), 32'd4);
    chk("p6_stall_gv", 32'(grant_valid), 32'd1);
    cyc();
    #1;
    chk("p6_hold_wr", 32'(fifo_wr_en), 32'd0);
    fifo_rd_en = 1'b1;
    cyc();
    fifo_rd_en = 1'b0;
    #1;
    chk("p6_pulse_occ", 32'(occupancy), 32'd3);
    chk("p6_pulse_wr", 32'(fifo_wr_en), 32'd1);
    chk("p6_pulse_data", 32'(fifo_wr_data), 32'hC004);
    cyc();
    set_data(0, 16'hC005);
    req_last = 4'b0001;
    #1;
    chk("p6_one_beat_occ", 32'(occupancy), 32'd4);
    chk("p6_one_beat_wr", 32'(fifo_wr_en), 32'd0);
    fifo_rd_en = 1'b1;
    cyc();
    fifo_rd_en = 1'b0;
    #1;
    chk("p6_last_wr", 32'(fifo_wr_en), 32'd1);
    chk("p6_last_data", 32'(fifo_wr_data), 32'hC005);
    cyc();
    req_last = '0;
    #1;
    chk("p6_done_occ", 32'(occupancy), 32'd4);
    chk("p6_done_gv", 32'(grant_valid), 32'd0);

    // FIFO restart: count forced to zero, arbitration and lock frozen
    fifo_busy = 1'b1;
    #1;
    chk("busy_ready", 32'(req_ready), 32'd0);
    cyc();
    #1;
    chk("busy_occ", 32'(occupancy), 32'd0);
    chk("busy_idle_held", 32'(grant_valid), 32'd0);
    fifo_busy = 1'b0;
    cyc();
    #1;
    chk("busy_lock", 32'(grant_valid), 32'd1);
    chk("busy_lock_wr", 32'(fifo_wr_en), 32'd1);
    fifo_busy = 1'b1;
    #1;
    chk("busy_mid_wr", 32'(fifo_wr_en), 32'd0);
    cyc();
    #1;
    chk("busy_mid_gv", 32'(grant_valid), 32'd1);
    chk("busy_mid_state", 32'(state_dbg), 32'(LOCKED));
    chk("busy_mid_occ", 32'(occupancy), 32'd0);
    fifo_busy = 1'b0;
    #1;
    chk("busy_resume_wr", 32'(fifo_wr_en), 32'd1);
    req_valid = '0;
    #1;
    chk("novalid_wr", 32'(fifo_wr_en), 32'd0);

    // Underflow and error latch
    fifo_rd_en = 1'b1;
    #1;
    chk("uf_pre_err", 32'(err_sticky), 32'd0);
    cyc();
    fifo_rd_en = 1'b0;
    #1;
    chk("uf_err", 32'(err_sticky), 32'd1);
    chk("uf_occ", 32'(occupancy), 32'd0);
    err_clr     = 1'b1;
    fifo_wr_err = 1'b1;
    cyc();
    fifo_wr_err = 1'b0;
    #1;
    chk("err_set_wins", 32'(err_sticky), 32'd1);
    cyc();
    err_clr = 1'b0;
    #1;
    chk("err_cleared", 32'(err_sticky), 32'd0);
    fifo_rd_err = 1'b1;
    cyc();
    fifo_rd_err = 1'b0;
    #1;
    chk("rd_err_set", 32'(err_sticky), 32'd1);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    #1;
    chk("rd_err_clr", 32'(err_sticky), 32'd0);

    // Asynchronous reset in the middle of a packet from requester 2
    do_reset();
    req_valid = 4'b0100;
    req_last  = '0;
    set_data(2, 16'hD000);
    cyc();
    #1;
    chk("mid_gidx", 32'(grant_idx), 32'd2);
    chk("mid_wr", 32'(fifo_wr_en), 32'd1);
    chk("mid_data", 32'(fifo_wr_data), 32'hD000);
    cyc();
    #1;
    chk("mid_occ", 32'(occupancy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_gv", 32'(grant_valid), 32'd0);
    chk("async_gidx", 32'(grant_idx), 32'd0);
    chk("async_wr", 32'(fifo_wr_en), 32'd0);
    chk("async_ready", 32'(req_ready), 32'd0);
    chk("async_occ", 32'(occupancy), 32'd0);
    cyc();
    reset_n   = 1'b1;
    req_valid = 4'b0101;
    #1;
    chk("post_rst_idle", 32'(grant_valid), 32'd0);
    cyc();
    #1;
    chk("post_rst_gidx", 32'(grant_idx), 32'd0);
    chk("post_rst_gv", 32'(grant_valid), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the write port of one sync_fifo_controller instance among NUM_REQ requesters, using packet-locked round-robin arbitration.
- Keeps its own shadow occupancy count and only issues a write when a slot is guaranteed free. This is needed because the FIFO's registered fifo_full lags by one cycle.
- Sits between the producer engines and the FIFO write interface. It taps the consumer's fifo_rd_en to return credits.

Parameters:
- NUM_REQ, 4, number of requesters (>=2)
- DATA_WIDTH, 32, word width; matches the FIFO
- FIFO_DEPTH, 32, SIZE of the attached FIFO
- IDX_WIDTH, $clog2(NUM_REQ), width of the grant index
- CNT_WIDTH, $clog2(FIFO_DEPTH)+1, width of the occupancy counter

Ports:
- clk  in  1  clock; the only clock domain
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester word valid
- req_last  in  NUM_REQ  per-requester last word of packet
- req_data  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  per-requester accept
- fifo_wr_en  out  1  to FIFO fifo_wr_en
- fifo_wr_data  out  DATA_WIDTH  to FIFO fifo_wr_data
- fifo_rd_en  in  1  tap of the consumer's read strobe to the FIFO
- fifo_busy  in  1  FIFO in reset (bram_rst_busy or FIFO reset)
- fifo_wr_err  in  1  from FIFO
- fifo_rd_err  in  1  from FIFO
- grant_valid  out  1  a requester currently holds the lock
- grant_idx  out  IDX_WIDTH  locked requester
- occupancy  out  CNT_WIDTH  shadow word count
- err_sticky  out  1  latched FIFO error or shadow-count underflow
- err_clr  in  1  clears err_sticky

Behaviour:
- Reset values (reset_n low, asynchronous): state IDLE, grant_valid 0, grant_idx 0, rr_ptr NUM_REQ-1 (so requester 0 has first priority), occupancy 0, err_sticky 0.
- Reset outputs: req_ready all 0, fifo_wr_en 0.
- space = (occupancy < FIFO_DEPTH) & ~fifo_busy. It is combinational from registered state only.
- Handshake outputs are combinational, with zero added latency:
  - req_ready[i] = (state==LOCKED) & (grant_idx==i) & space.
  - fifo_wr_en = req_ready[grant_idx] & req_valid[grant_idx].
  - fifo_wr_data = the grant_idx slice of req_data.
  - A beat transfers in any cycle where fifo_wr_en=1.
- Requesters hold req_valid, data and last stable until accepted. Deasserting req_valid mid-packet is legal; the lock is kept.
- FSM IDLE:
  - If any req_valid is set, grant the first set index searching rr_ptr+1, rr_ptr+2, ... (mod NUM_REQ).
  - Register grant_idx, set grant_valid=1 and go to LOCKED.
  - Arbitration costs 1 cycle. No transfer happens in IDLE.
- FSM LOCKED:
  - On a transfer with req_last[grant_idx]=1: set rr_ptr=grant_idx, grant_valid=0, go to IDLE.
  - Otherwise remain in LOCKED.
  - Minimum gap between packets is one IDLE cycle.
- Occupancy update: wr = fifo_wr_en; rd = fifo_rd_en & (occupancy!=0).
  - wr & ~rd: +1
  - rd & ~wr: -1
  - both: unchanged
  - fifo_rd_en with occupancy==0: count unchanged, set err_sticky.
- Full boundary: at occupancy==FIFO_DEPTH, no write is issued, even if fifo_rd_en is high in the same cycle. Writing resumes the next cycle.
- fifo_busy high:
  - space=0.
  - occupancy forced to 0 synchronously, because the FIFO is restarting.
  - The lock and FSM state are held.
- err_sticky:
  - Set on fifo_wr_err, fifo_rd_err or shadow underflow.
  - Cleared by err_clr. Set has priority over a simultaneous err_clr.
- Reset mid-packet: the packet is dropped with no recovery. The FIFO must be reset from the same source so the shadow count stays consistent.
- Width rules:
  - occupancy wraps never; it is bounded to 0..FIFO_DEPTH.
  - rr_ptr increment wraps at NUM_REQ, not at 2^IDX_WIDTH.

Decomposition:
- Package fifo_arb_pkg holds:
  - the state enum (IDLE, LOCKED);
  - a function rr_next(rr_ptr, req_valid), which returns the grant index and a found flag.
- Sub-module rr_priority_picker (combinational, parameter NUM_REQ) implements the rotating priority search. It is reusable for the read-side scheduler.
- The credit counter and FSM stay in the top module.

Test Plan:
- Reset then req_valid=4'b0001, a 3-beat packet -> IDLE 1 cycle, then grant_idx=0 and 3 consecutive fifo_wr_en. Occupancy reaches 3 and grant_valid drops after the last beat.
- req_valid=4'b1111, each requester sends a 1-beat packet repeatedly -> grant order 0,1,2,3,0 with one IDLE cycle between packets.
- FIFO_DEPTH=4, no reads, 6-beat packet -> 4 beats accepted and req_ready=0 with occupancy=4. A single fifo_rd_en pulse -> exactly one more beat, the cycle after the pulse.
- occupancy=4 with simultaneous fifo_rd_en and a pending beat -> no write that cycle, occupancy 3, write the next cycle, occupancy back to 4.
- fifo_rd_en at occupancy=0 -> occupancy stays 0 and err_sticky=1. err_clr -> err_sticky=0 the next cycle.
- reset_n pulsed low mid-packet with grant_idx=2 -> outputs reset immediately (asynchronously). After release, requester 0 wins first.
